// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core and loader/DMA ports,
// generating byte strobes and sign/zero-extending sub-word loads.
module dmem_arbiter #(
    parameter int DM_ADDRESS    = 9,
    parameter int DATA_W        = 32,
    parameter int CORE_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [2:0]            c_funct3,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_wr,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, sel_q, sel_d, err_q, err_d;
    logic [2:0] f3_q, f3_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic idle, c_win, d_win, win, w_we, w_err;
    logic [2:0] w_f3;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata, lane, ld_fmt;
    logic [3:0] w_mask;
    // last_q/sel_q: 1 means the loader/DMA port
    always_comb begin
        idle    = (state_q == IDLE) && reset_n;
        c_win   = idle && c_req && (!d_req || CORE_PRIORITY != 0 || last_q);
        d_win   = idle && d_req && !c_win;
        win     = c_win || d_win;
        w_we    = d_win ? d_we : c_we;
        w_f3    = d_win ? d_funct3 : c_funct3;
        w_addr  = d_win ? d_addr : c_addr;
        w_wdata = d_win ? d_wdata : c_wdata;
        w_err   = win && ((w_we ? w_f3[2] : (w_f3[2] && w_f3[1])) || w_f3[1:0] == 2'b11 ||
                  (w_f3[1:0] == 2'b01 && w_addr[0]) || (w_f3[1:0] == 2'b10 && w_addr[1:0] != 2'b00));
        w_mask  = w_f3[1:0] == 2'b00 ? 4'b0001 << w_addr[1:0] :
                  w_f3[1:0] == 2'b01 ? 4'b0011 << {w_addr[1], 1'b0} : 4'b1111;
        lane    = mem_rdata >> {addr_q[1:0], 3'b000};
        ld_fmt  = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] && lane[7]}}, lane[7:0]} :
                  f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] && lane[15]}}, lane[15:0]} : mem_rdata;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == IDLE    ? (win ? ((w_err || w_we) ? RESP : RD_WAIT) : IDLE) :
                  state_q == RD_WAIT ? RESP : IDLE;
    end
    always_comb begin
        last_d    = win ? d_win : last_q;
        sel_d     = win ? d_win : sel_q;
        err_d     = win ? w_err : err_q;
        f3_d      = win ? w_f3 : f3_q;
        addr_d    = win ? w_addr : addr_q;
        c_rdata_d = (c_win && w_err) ? '0 : (state_q == RD_WAIT && !sel_q) ? ld_fmt : c_rdata_q;
        d_rdata_d = (d_win && w_err) ? '0 : (state_q == RD_WAIT && sel_q) ? ld_fmt : d_rdata_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            err_q     <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            last_q    <= last_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            f3_q      <= f3_d;
            addr_q    <= addr_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end
    always_comb begin
        c_gnt     = c_win;
        d_gnt     = d_win;
        c_rvalid  = state_q == RESP && !sel_q;
        d_rvalid  = state_q == RESP && sel_q;
        c_err     = c_rvalid && err_q;
        d_err     = d_rvalid && err_q;
        c_rdata   = c_rdata_q;
        d_rdata   = d_rdata_q;
        mem_addr  = win ? {w_addr[DM_ADDRESS-1:2], 2'b00} :
                    state_q != IDLE ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;
        mem_wdata = !win ? '0 : w_f3[1:0] == 2'b00 ? {4{w_wdata[7:0]}} :
                    w_f3[1:0] == 2'b01 ? {2{w_wdata[15:0]}} : w_wdata;
        mem_wr    = (win && w_we && !w_err) ? w_mask : 4'b0000;
        mem_re    = win && !w_we && !w_err;
    end
endmodule
